ft_recovery_seq: RTL and testbench
==================================

// Module: ft_recovery_seq
// PURPOSE
//  Downstream of the fault-tolerance manager: consumes recover_o and returns done_i.
//  On a recovery request, halts the lockstep cores and copies the safe register file
//  (regs 1..NUM_REGS-1) from ft_memory into the core register files.
//  Then loads the saved PC and pulses done for one cycle.
// PARAMETERS
//  ADDR_WIDTH  5   register address width
//  DATA_WIDTH  32  register/PC data width
//  NUM_REGS    32  registers in safe file; x0 never copied (hardwired zero)
// PORTS
//  clk_i         in   1           clock
//  rst_ni        in   1           async active-low reset
//  recover_i     in   1           recovery request from ft_control (level)
//  safe_raddr_o  out  ADDR_WIDTH  read address into safe register file
//  safe_rdata_i  in   DATA_WIDTH  read data, valid 1 cycle after safe_raddr_o
//  safe_pc_i     in   DATA_WIDTH  saved PC from safe memory
//  rf_we_o       out  1           core register-file write enable (both cores)
//  rf_waddr_o    out  ADDR_WIDTH  core register-file write address
//  rf_wdata_o    out  DATA_WIDTH  core register-file write data
//  pc_load_o     out  1           one-cycle PC load strobe to cores
//  pc_o          out  DATA_WIDTH  PC value, valid with pc_load_o
//  halt_o        out  1           cores held, high in every non-IDLE state
//  done_o        out  1           one-cycle recovery-complete pulse (to done_i)
//  err_o         out  1           checksum mismatch, valid with done_o (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=1, recover_q=0, all outputs 0 (safe_raddr_o=0).
//  Start condition: recover_i=1 && recover_q=0 in IDLE (rising edge).
//   - recover_q is a registered copy of recover_i.
//   - A level held high through DONE does not restart recovery.
//  States:
//   - IDLE:  halt_o=0. On start -> COPY with cnt=1.
//   - COPY:  safe_raddr_o=cnt, cnt increments each cycle.
//            -> FLUSH after the cycle with cnt=NUM_REGS-1.
//   - FLUSH: one cycle for the last read to return. -> PC.
//   - PC:    pc_load_o=1, pc_o=safe_pc_i. -> DONE.
//   - DONE:  done_o=1, err_o valid. -> IDLE.
//  Write path:
//   - rf_we_o/rf_waddr_o are the previous cycle's COPY read, delayed one register stage.
//   - rf_wdata_o=safe_rdata_i.
//   - Writes are addr 1..NUM_REGS-1, in order, contiguous, one per cycle.
//   - rf_we_o is never asserted outside COPY+FLUSH.
//  Timing (start sampled at edge 0, NUM_REGS=32):
//   - COPY cycles 1..31; writes cycles 2..32 (FLUSH carries the write to addr 31).
//   - PC at cycle 33; done_o at cycle 34.
//   - Total = NUM_REGS+2 cycles.
//  cnt is ADDR_WIDTH bits wide and does not wrap. The terminal test is cnt==NUM_REGS-1.
//  recover_i toggling while not IDLE is ignored. It is only sampled into recover_q.
//  Async reset mid-sequence:
//   - Immediately returns to IDLE, outputs 0.
//   - No further writes, no done_o.
//   - A partial copy is left as-is.
// CONFIGURATION
//  FT_RECOVERY_CHECKSUM_EN defined:
//   - Extra input safe_chk_i [DATA_WIDTH-1:0].
//   - Running XOR: cleared on start, XORs every rf_wdata_o written, then pc_o in PC.
//   - In DONE, err_o = (xor != safe_chk_i).
//  FT_RECOVERY_CHECKSUM_EN undefined:
//   - No safe_chk_i port, no accumulator; err_o tied 0.
// TESTING
//  1. Reset, then recover_i pulse with safe reg k = 32'h1000_0000+k and safe_pc_i=32'h0000_0080:
//     writes addr 1..31 with those data in cycles 2..32; pc_load_o and pc_o=0x80 in cycle 33;
//     done_o in cycle 34; halt_o high in cycles 1..34.
//  2. recover_i held high through DONE and 10 more cycles -> exactly one sequence.
//     Drop recover_i, re-raise it -> second sequence starts.
//  3. rst_ni low during COPY at cnt=10 -> all outputs 0 immediately, no done_o.
//     A fresh recover_i after reset restarts from addr 1.
//  4. Toggle recover_i every cycle during COPY -> write order and timing identical to test 1.
//  5. NUM_REGS=16 build -> writes addr 1..15; done_o at cycle 18.
//  6. With FT_RECOVERY_CHECKSUM_EN:
//     - Matching safe_chk_i -> err_o=0 with done_o.
//     - Flipping bit 0 of reg 7 data -> err_o=1 with done_o.

Source files
------------

// File: rtl/ft_recovery_seq.sv
// Recovery sequencer: halts the lockstep cores, restores regs 1..NUM_REGS-1 from safe memory, reloads PC, pulses done.
// Optional running-XOR checksum of the restored state is enabled by defining FT_RECOVERY_CHECKSUM_EN.
module ft_recovery_seq #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  recover_i,
  output logic [ADDR_WIDTH-1:0] safe_raddr_o,
  input  logic [DATA_WIDTH-1:0] safe_rdata_i,
  input  logic [DATA_WIDTH-1:0] safe_pc_i,
`ifdef FT_RECOVERY_CHECKSUM_EN
  input  logic [DATA_WIDTH-1:0] safe_chk_i,
`endif
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  pc_load_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  halt_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {S_IDLE, S_COPY, S_FLUSH, S_PC, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_REG = ADDR_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    recover_q;
  logic                    start;
  logic [ADDR_WIDTH-1:0]   raddr_d, waddr_d;
  logic                    we_d, pc_load_d, halt_d, done_d;
  logic [DATA_WIDTH-1:0]   pc_d;

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start     = recover_i && !recover_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COPY;
          cnt_d   = FIRST_REG;
        end
      end
      S_COPY: begin
        if (cnt_q == LAST_REG) state_d = S_FLUSH;
        else                   cnt_d   = cnt_q + FIRST_REG;
      end
      S_FLUSH: state_d = S_PC;
      S_PC:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    halt_d    = (state_d != S_IDLE);
    raddr_d   = (state_d == S_COPY) ? cnt_d : '0;
    // Write port trails the read port by one stage to match memory read latency.
    we_d      = (state_q == S_COPY);
    waddr_d   = (state_q == S_COPY) ? cnt_q : '0;
    pc_load_d = (state_d == S_PC);
    pc_d      = (state_d == S_PC) ? safe_pc_i : '0;
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= FIRST_REG;
      recover_q    <= 1'b0;
      safe_raddr_o <= '0;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      pc_load_o    <= 1'b0;
      pc_o         <= '0;
      halt_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      recover_q    <= recover_i;
      safe_raddr_o <= raddr_d;
      rf_we_o      <= we_d;
      rf_waddr_o   <= waddr_d;
      pc_load_o    <= pc_load_d;
      pc_o         <= pc_d;
      halt_o       <= halt_d;
      done_o       <= done_d;
    end
  end

  // Read data arrives one cycle after the address, so it is forwarded straight to the write port.
  assign rf_wdata_o = rf_we_o ? safe_rdata_i : '0;

`ifdef FT_RECOVERY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] xor_q, xor_d;
  logic                  err_q, err_d;

  // Running XOR over every restored word and the reloaded PC.
  always_comb begin
    xor_d = xor_q;
    if (state_q == S_IDLE && state_d == S_COPY) begin
      xor_d = '0;
    end else begin
      if (rf_we_o)          xor_d = xor_d ^ safe_rdata_i;
      if (state_q == S_PC)  xor_d = xor_d ^ pc_o;
    end
    err_d = (state_d == S_DONE) && (xor_d != safe_chk_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xor_q <= '0;
      err_q <= 1'b0;
    end else begin
      xor_q <= xor_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ft_recovery_seq.sv
// Scoreboard bench for ft_recovery_seq: per-cycle expected outputs queued at stimulus, popped by a negedge monitor.
module tb_ft_recovery_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        recover, recover16;
  logic [4:0]  raddr, waddr, raddr16, waddr16;
  logic [31:0] rdata, wdata, pc_in, pc_out, rdata16, wdata16, pc_out16, chk;
  logic        we, pc_load, halt, done, err;
  logic        we16, pc_load16, halt16, done16, err16;

  always #5 clk = ~clk;

  ft_recovery_seq #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .recover_i(recover),
    .safe_raddr_o(raddr), .safe_rdata_i(rdata), .safe_pc_i(pc_in),
`ifdef FT_RECOVERY_CHECKSUM_EN
    .safe_chk_i(chk),
`endif
    .rf_we_o(we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
    .pc_load_o(pc_load), .pc_o(pc_out), .halt_o(halt), .done_o(done), .err_o(err)
  );

  ft_recovery_seq #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_REGS(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .recover_i(recover16),
    .safe_raddr_o(raddr16), .safe_rdata_i(rdata16), .safe_pc_i(pc_in),
`ifdef FT_RECOVERY_CHECKSUM_EN
    .safe_chk_i(chk),
`endif
    .rf_we_o(we16), .rf_waddr_o(waddr16), .rf_wdata_o(wdata16),
    .pc_load_o(pc_load16), .pc_o(pc_out16), .halt_o(halt16), .done_o(done16), .err_o(err16)
  );

  // Safe register file model with one-cycle read latency.
  logic [31:0] mem [0:31];
  always @(posedge clk) begin
    rdata   <= mem[raddr];
    rdata16 <= mem[raddr16];
  end

  typedef struct {
    logic        halt;
    logic        raddr_v;
    logic [4:0]  raddr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        pc_load;
    logic [31:0] pc;
    logic        done;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Queue the 34 cycles of one full recovery, starting with the cycle after the start edge.
  task automatic push_seq(input logic exp_err);
    for (int c = 1; c <= 34; c++) begin
      exp_t e;
      e.halt    = 1'b1;
      e.raddr_v = (c <= 31);
      e.raddr   = 5'(c);
      e.we      = (c >= 2 && c <= 32);
      e.waddr   = 5'(c - 1);
      e.wdata   = e.we ? mem[c-1] : 32'h0;
      e.pc_load = (c == 33);
      e.pc      = pc_in;
      e.done    = (c == 34);
      e.err     = exp_err;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      exp_t e;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e = '{halt: 1'b0, raddr_v: 1'b0, raddr: 5'd0, we: 1'b0, waddr: 5'd0,
              wdata: 32'h0, pc_load: 1'b0, pc: 32'h0, done: 1'b0, err: 1'b0};
      end
      check("halt", 32'(halt), 32'(e.halt));
      check("we", 32'(we), 32'(e.we));
      check("pc_load", 32'(pc_load), 32'(e.pc_load));
      check("done", 32'(done), 32'(e.done));
      if (e.raddr_v) check("raddr", 32'(raddr), 32'(e.raddr));
      if (e.we) begin
        check("waddr", 32'(waddr), 32'(e.waddr));
        check("wdata", wdata, e.wdata);
      end
      if (e.pc_load) check("pc", pc_out, e.pc);
      if (e.done) check("err", 32'(err), 32'(e.err));
    end
  end

  logic flip_err;

  initial begin
    rst_n     = 1'b0;
    recover   = 1'b0;
    recover16 = 1'b0;
    pc_in     = 32'h0000_0080;
    mem[0]    = 32'h0;
    for (int k = 1; k < 32; k++) mem[k] = 32'h1000_0000 + 32'(k);
    chk = pc_in;
    for (int k = 1; k < 32; k++) chk = chk ^ mem[k];
`ifdef FT_RECOVERY_CHECKSUM_EN
    flip_err = 1'b1;
`else
    flip_err = 1'b0;
`endif

    // Reset state
    #2;
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_we", 32'(we), 32'h0);
    check("rst_raddr", 32'(raddr), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pc_load", 32'(pc_load), 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    repeat (2) tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) tick();

    // Single pulse: full sequence
    recover = 1'b1; push_seq(1'b0);
    tick(); recover = 1'b0;
    repeat (40) tick();
    check("q_empty_t1", 32'(exp_q.size()), 32'h0);

    // Level held through DONE and beyond: one sequence only, then re-arm
    recover = 1'b1; push_seq(1'b0);
    repeat (44) tick();
    recover = 1'b0;
    repeat (2) tick();
    recover = 1'b1; push_seq(1'b0);
    tick(); recover = 1'b0;
    repeat (40) tick();
    check("q_empty_t2", 32'(exp_q.size()), 32'h0);

    // Async reset during COPY at cnt=10
    recover = 1'b1; push_seq(1'b0);
    tick(); recover = 1'b0;
    repeat (9) tick();
    check("pre_rst_raddr", 32'(raddr), 32'd10);
    rst_n  = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_halt", 32'(halt), 32'h0);
    check("mid_rst_we", 32'(we), 32'h0);
    check("mid_rst_raddr", 32'(raddr), 32'h0);
    check("mid_rst_waddr", 32'(waddr), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_no_done", 32'(done), 32'h0);
      check("rst_no_we", 32'(we), 32'h0);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) tick();
    recover = 1'b1; push_seq(1'b0);
    tick(); recover = 1'b0;
    repeat (40) tick();
    check("q_empty_t3", 32'(exp_q.size()), 32'h0);

    // recover_i toggling during COPY is ignored
    recover = 1'b1; push_seq(1'b0);
    for (int i = 0; i < 31; i++) begin
      tick();
      recover = (i == 0) ? 1'b0 : ~recover;
    end
    tick(); recover = 1'b0;
    repeat (40) tick();
    check("q_empty_t4", 32'(exp_q.size()), 32'h0);

    // Corrupted reg 7 against the original checksum
    mem[7] = mem[7] ^ 32'h1;
    recover = 1'b1; push_seq(flip_err);
    tick(); recover = 1'b0;
    repeat (40) tick();
    check("q_empty_t6", 32'(exp_q.size()), 32'h0);
    mem[7] = mem[7] ^ 32'h1;

    // NUM_REGS=16 instance: writes 1..15, done at cycle 18
    recover16 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      recover16 = 1'b0;
      check("n16_we", 32'(we16), 32'(c >= 2 && c <= 16));
      if (c >= 2 && c <= 16) begin
        check("n16_waddr", 32'(waddr16), 32'(c - 1));
        check("n16_wdata", wdata16, mem[c-1]);
      end
      check("n16_pc_load", 32'(pc_load16), 32'(c == 17));
      check("n16_done", 32'(done16), 32'(c == 18));
      check("n16_halt", 32'(halt16), 32'(c <= 18));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
